// File: rtl/decode_pkg.sv
// Shared widths and encodings for the decode/register-file stage.
package decode_pkg;

   localparam int unsigned DW_DEFAULT = 32;
   localparam int unsigned AW_DEFAULT = 5;
   localparam int unsigned IW_DEFAULT = 16;

   // IMD_SE encoding
   localparam logic EXT_ZERO = 1'b0;
   localparam logic EXT_SIGN = 1'b1;

   // REG_RD / REG_WR are active-low strobes
   localparam logic EN_ACTIVE = 1'b0;

endpackage

// File: rtl/rf_2r1w.sv
// Two-read/one-write register file with combinational read, write-to-read bypass
// and optional hardwired-zero R0.
module rf_2r1w
   import decode_pkg::*;
#(
   parameter int unsigned DW      = DW_DEFAULT,
   parameter int unsigned AW      = AW_DEFAULT,
   parameter bit          ZERO_R0 = 1'b1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [DW-1:0] wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   input  logic [AW-1:0] raddr_b_i,
   output logic [DW-1:0] rdata_a_o,
   output logic [DW-1:0] rdata_b_o,
   output logic          wr_eff_o
);

   localparam int unsigned NumRegs = 2 ** AW;

   logic [DW-1:0] mem_q [NumRegs];
   logic          wr_eff;

   assign wr_eff   = we_i && !(ZERO_R0 && (waddr_i == '0));
   assign wr_eff_o = wr_eff;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NumRegs; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_eff) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_a_o = mem_q[raddr_a_i];
      if (ZERO_R0 && (raddr_a_i == '0)) begin
         rdata_a_o = '0;
      end else if (wr_eff && (waddr_i == raddr_a_i)) begin
         rdata_a_o = wdata_i;
      end
   end

   always_comb begin
      rdata_b_o = mem_q[raddr_b_i];
      if (ZERO_R0 && (raddr_b_i == '0)) begin
         rdata_b_o = '0;
      end else if (wr_eff && (waddr_i == raddr_b_i)) begin
         rdata_b_o = wdata_i;
      end
   end

endmodule

// File: rtl/decode_rf_pipe.sv
// Decode stage: register file reads, immediate extension, stall-holding output
// registers and a pending-write scoreboard raising HAZARD on RAW dependencies.
module decode_rf_pipe
   import decode_pkg::*;
#(
   parameter int unsigned DW      = DW_DEFAULT,
   parameter int unsigned AW      = AW_DEFAULT,
   parameter int unsigned IW      = IW_DEFAULT,
   parameter bit          ZERO_R0 = 1'b1
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [AW-1:0] DIR_A,
   input  logic [AW-1:0] DIR_B,
   input  logic [AW-1:0] DIR_WRA,
   input  logic [DW-1:0] DI,
   input  logic          REG_RD,
   input  logic          REG_WR,
   input  logic [IW-1:0] IMD,
   input  logic          IMD_SE,
   input  logic          STALL,
   input  logic          PND_SET,
   input  logic [AW-1:0] DIR_PND,
   output logic [DW-1:0] DOA,
   output logic [DW-1:0] DOB,
   output logic [DW-1:0] IMD_EXT,
   output logic          VALID_OUT,
   output logic          HAZARD
);

   localparam int unsigned NumRegs = 2 ** AW;

   logic [DW-1:0]      rdata_a, rdata_b, imd_ext;
   logic               wr_eff, rd_en, hazard_now;
   logic [DW-1:0]      doa_d, doa_q, dob_d, dob_q, imd_d, imd_q;
   logic               valid_d, valid_q, hazard_d, hazard_q;
   logic [NumRegs-1:0] pend_d, pend_q;

   rf_2r1w #(
      .DW      (DW),
      .AW      (AW),
      .ZERO_R0 (ZERO_R0)
   ) u_rf (
      .clk_i     (CLK),
      .rst_i     (RST),
      .we_i      (REG_WR == EN_ACTIVE),
      .waddr_i   (DIR_WRA),
      .wdata_i   (DI),
      .raddr_a_i (DIR_A),
      .raddr_b_i (DIR_B),
      .rdata_a_o (rdata_a),
      .rdata_b_o (rdata_b),
      .wr_eff_o  (wr_eff)
   );

   assign rd_en   = (REG_RD == EN_ACTIVE);
   assign imd_ext = (IMD_SE == EXT_SIGN) ? {{(DW - IW){IMD[IW-1]}}, IMD}
                                         : {{(DW - IW){1'b0}}, IMD};

   // A source retired by this cycle's write is served by the bypass, so not hazardous.
   assign hazard_now = (pend_q[DIR_A] && !(wr_eff && (DIR_WRA == DIR_A)))
                    || (pend_q[DIR_B] && !(wr_eff && (DIR_WRA == DIR_B)));

   always_comb begin
      pend_d = pend_q;
      if (wr_eff) begin
         pend_d[DIR_WRA] = 1'b0;
      end
      if (PND_SET && !(ZERO_R0 && (DIR_PND == '0))) begin
         pend_d[DIR_PND] = 1'b1;
      end
   end

   always_comb begin
      doa_d    = doa_q;
      dob_d    = dob_q;
      imd_d    = imd_q;
      valid_d  = valid_q;
      hazard_d = hazard_q;
      if (!STALL) begin
         if (rd_en) begin
            doa_d    = rdata_a;
            dob_d    = rdata_b;
            imd_d    = imd_ext;
            valid_d  = 1'b1;
            hazard_d = hazard_now;
         end else begin
            valid_d  = 1'b0;
            hazard_d = 1'b0;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         doa_q    <= '0;
         dob_q    <= '0;
         imd_q    <= '0;
         valid_q  <= 1'b0;
         hazard_q <= 1'b0;
         pend_q   <= '0;
      end else begin
         doa_q    <= doa_d;
         dob_q    <= dob_d;
         imd_q    <= imd_d;
         valid_q  <= valid_d;
         hazard_q <= hazard_d;
         pend_q   <= pend_d;
      end
   end

   assign DOA       = doa_q;
   assign DOB       = dob_q;
   assign IMD_EXT   = imd_q;
   assign VALID_OUT = valid_q;
   assign HAZARD    = hazard_q;

endmodule

// File: tb/tb_decode_rf_pipe.sv
// Directed bench for decode_rf_pipe: expected outputs queued per step, checked after the edge.
module tb_decode_rf_pipe;

   logic        CLK = 1'b0;
   logic        RST;
   logic [4:0]  DIR_A, DIR_B, DIR_WRA, DIR_PND;
   logic [31:0] DI;
   logic        REG_RD, REG_WR, IMD_SE, STALL, PND_SET;
   logic [15:0] IMD;
   logic [31:0] DOA, DOB, IMD_EXT;
   logic        VALID_OUT, HAZARD;

   int tests = 0;
   int fails = 0;

   typedef struct {
      string       tag;
      logic [31:0] doa;
      logic [31:0] dob;
      logic [31:0] imd;
      logic        valid;
      logic        hazard;
   } exp_t;

   exp_t sb[$];

   decode_rf_pipe dut (
      .CLK       (CLK),
      .RST       (RST),
      .DIR_A     (DIR_A),
      .DIR_B     (DIR_B),
      .DIR_WRA   (DIR_WRA),
      .DI        (DI),
      .REG_RD    (REG_RD),
      .REG_WR    (REG_WR),
      .IMD       (IMD),
      .IMD_SE    (IMD_SE),
      .STALL     (STALL),
      .PND_SET   (PND_SET),
      .DIR_PND   (DIR_PND),
      .DOA       (DOA),
      .DOB       (DOB),
      .IMD_EXT   (IMD_EXT),
      .VALID_OUT (VALID_OUT),
      .HAZARD    (HAZARD)
   );

   always #5 CLK = ~CLK;

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
         $error("comparison %s failed", tag);
      end
   endtask

   task automatic expect_out(input string tag, input logic [31:0] doa, input logic [31:0] dob,
                             input logic [31:0] imd, input logic valid, input logic hazard);
      exp_t e;
      e.tag = tag; e.doa = doa; e.dob = dob; e.imd = imd; e.valid = valid; e.hazard = hazard;
      sb.push_back(e);
   endtask

   // Advance one clock, then retire every queued expectation against the outputs.
   task automatic step();
      exp_t e;
      @(posedge CLK);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         cmp({e.tag, ".doa"}, DOA, e.doa);
         cmp({e.tag, ".dob"}, DOB, e.dob);
         cmp({e.tag, ".imd"}, IMD_EXT, e.imd);
         cmp({e.tag, ".valid"}, {31'd0, VALID_OUT}, {31'd0, e.valid});
         cmp({e.tag, ".hazard"}, {31'd0, HAZARD}, {31'd0, e.hazard});
      end
   endtask

   task automatic idle();
      RST = 1'b0; REG_RD = 1'b1; REG_WR = 1'b1; STALL = 1'b0; PND_SET = 1'b0;
   endtask

   initial begin
      idle();
      DIR_A = '0; DIR_B = '0; DIR_WRA = '0; DIR_PND = '0; DI = '0;
      IMD = 16'h8001; IMD_SE = 1'b1;

      RST = 1'b1;
      expect_out("reset", 0, 0, 0, 0, 0);
      step();

      idle(); REG_WR = 1'b0; DIR_WRA = 5'd12; DI = 32'd36;
      expect_out("wr12", 0, 0, 0, 0, 0);
      step();
      DIR_WRA = 5'd15; DI = 32'd5;
      expect_out("wr15", 0, 0, 0, 0, 0);
      step();

      idle(); REG_RD = 1'b0; DIR_A = 5'd12; DIR_B = 5'd15; IMD_SE = 1'b1;
      expect_out("rd12_15", 32'd36, 32'd5, 32'hFFFF8001, 1, 0);
      step();

      REG_WR = 1'b0; DIR_WRA = 5'd7; DI = 32'hDEADBEEF; DIR_A = 5'd7; DIR_B = 5'd7;
      IMD_SE = 1'b0;
      expect_out("bypass", 32'hDEADBEEF, 32'hDEADBEEF, 32'h00008001, 1, 0);
      step();

      DIR_WRA = 5'd0; DI = 32'd99; DIR_A = 5'd0; DIR_B = 5'd12; IMD_SE = 1'b1;
      expect_out("r0_wr_rd", 0, 32'd36, 32'hFFFF8001, 1, 0);
      step();
      REG_WR = 1'b1; DIR_B = 5'd15;
      expect_out("r0_rd", 0, 32'd5, 32'hFFFF8001, 1, 0);
      step();

      DIR_A = 5'd12; DIR_B = 5'd15;
      expect_out("pre_stall", 32'd36, 32'd5, 32'hFFFF8001, 1, 0);
      step();
      STALL = 1'b1; DIR_A = 5'd15; IMD_SE = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_out($sformatf("stall%0d", i), 32'd36, 32'd5, 32'hFFFF8001, 1, 0);
         step();
      end
      STALL = 1'b0;
      expect_out("unstall", 32'd5, 32'd5, 32'h00008001, 1, 0);
      step();
      REG_RD = 1'b1;
      expect_out("no_read", 32'd5, 32'd5, 32'h00008001, 0, 0);
      step();

      PND_SET = 1'b1; DIR_PND = 5'd12;
      expect_out("pnd12", 32'd5, 32'd5, 32'h00008001, 0, 0);
      step();
      idle(); REG_RD = 1'b0; DIR_A = 5'd12; DIR_B = 5'd15;
      expect_out("haz12", 32'd36, 32'd5, 32'h00008001, 1, 1);
      step();
      REG_WR = 1'b0; DIR_WRA = 5'd12; DI = 32'd77;
      expect_out("wr_clr12", 32'd77, 32'd5, 32'h00008001, 1, 0);
      step();
      REG_WR = 1'b1;
      expect_out("cleared12", 32'd77, 32'd5, 32'h00008001, 1, 0);
      step();

      idle(); PND_SET = 1'b1; DIR_PND = 5'd20; REG_WR = 1'b0; DIR_WRA = 5'd20; DI = 32'd11;
      expect_out("set_wins", 32'd77, 32'd5, 32'h00008001, 0, 0);
      step();
      idle(); REG_RD = 1'b0; DIR_A = 5'd20; DIR_B = 5'd15;
      expect_out("haz20", 32'd11, 32'd5, 32'h00008001, 1, 1);
      step();

      idle(); PND_SET = 1'b1; DIR_PND = 5'd0;
      expect_out("pnd0", 32'd11, 32'd5, 32'h00008001, 0, 0);
      step();
      idle(); REG_RD = 1'b0; DIR_A = 5'd0; DIR_B = 5'd0;
      expect_out("no_haz0", 0, 0, 32'h00008001, 1, 0);
      step();

      idle(); REG_WR = 1'b0; DIR_WRA = 5'd3; DI = 32'h55; PND_SET = 1'b1; DIR_PND = 5'd3;
      expect_out("ld3", 0, 0, 32'h00008001, 0, 0);
      step();
      idle(); REG_RD = 1'b0; DIR_A = 5'd3; DIR_B = 5'd3;
      expect_out("haz3", 32'h55, 32'h55, 32'h00008001, 1, 1);
      step();
      RST = 1'b1; REG_WR = 1'b0; DIR_WRA = 5'd3; DI = 32'hAA;
      expect_out("rst_mid", 0, 0, 0, 0, 0);
      step();
      idle(); REG_RD = 1'b0; DIR_A = 5'd3; DIR_B = 5'd12;
      expect_out("post_rst", 0, 0, 32'h00008001, 1, 0);
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
